soc_system_alive_monitor: RTL and testbench

Heartbeat watchdog sitting directly downstream of the per-CPU alive-test PIO. It consumes the PIO's 2-bit `out_port` (bit 1 = "monitoring requested", bit 0 = heartbeat toggle). It times the interval between heartbeat toggles against a programmable timeout, counts heartbeats and misses, and raises a level interrupt on expiry. The supervising CPU reads and configures it through a 4-word Avalon-MM slave with the same zero-wait-state read style as the PIO.

---
 rtl/soc_system_alive_monitor_if.sv | 25 ++
 rtl/soc_system_alive_monitor.sv | 186 ++++++++++++++++++
 tb/tb_soc_system_alive_monitor.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_alive_monitor_if.sv
// Avalon-MM slave bus used by the supervising CPU to reach the alive monitor.
// The CPU side takes the master modport and the monitor takes the slave modport.
interface soc_system_alive_monitor_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/soc_system_alive_monitor.sv
// Heartbeat watchdog placed behind the per-CPU alive-test PIO.
// The monitor times the gap between heartbeat toggles against TIMEOUT, counts
// heartbeats and misses, and raises a sticky level interrupt when a gap expires.
module soc_system_alive_monitor #(
  parameter int unsigned TIMEOUT_DEFAULT = 32'd50000000,
  parameter int          CNT_W           = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [1:0]                       alive_in,
  soc_system_alive_monitor_if.slave        bus,
  output logic                             irq,
  output logic                             alive_ok
);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RUNNING  = 2'd2,
    EXPIRED  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_RST = CNT_W'(TIMEOUT_DEFAULT);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};

  state_t           state_r;
  state_t           state_next_s;
  logic [1:0]       alive_q_r;
  logic [1:0]       alive_qq_r;
  logic [CNT_W-1:0] timeout_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic [CNT_W-1:0] wr_timeout_s;
  logic [31:0]      timeout_rd_s;
  logic             enable_r;
  logic             irq_en_r;
  logic             timeout_flag_r;
  logic [15:0]      hb_cnt_r;
  logic [7:0]       miss_cnt_r;
  logic             hb_s;
  logic             req_s;
  logic             armed_ok_s;
  logic             wr_s;
  logic             expire_s;

  // Either edge of the synchronised toggle bit counts as one heartbeat.
  assign hb_s         = alive_q_r[0] ^ alive_qq_r[0];
  assign req_s        = alive_q_r[1];
  assign armed_ok_s   = enable_r & req_s;
  assign wr_s         = bus.chipselect & ~bus.write_n;
  assign wr_timeout_s = bus.writedata[CNT_W-1:0];
  assign timeout_rd_s = 32'(timeout_r);

  // Two-stage capture of the PIO output so heartbeat edges can be detected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alive_q_r  <= 2'b00;
      alive_qq_r <= 2'b00;
    end else begin
      alive_q_r  <= alive_in;
      alive_qq_r <= alive_q_r;
    end
  end

  // Next state and countdown value; a missing request or disable beats everything.
  always_comb begin
    state_next_s = state_r;
    count_next_s = count_r;
    expire_s     = 1'b0;
    if (!armed_ok_s) begin
      state_next_s = DISARMED;
      count_next_s = timeout_r;
    end else begin
      case (state_r)
        DISARMED: begin
          state_next_s = ARMED;
          count_next_s = timeout_r;
        end
        ARMED: begin
          if (hb_s) begin
            state_next_s = RUNNING;
            count_next_s = timeout_r;
          end else begin
            state_next_s = ARMED;
          end
        end
        RUNNING: begin
          if (hb_s) begin
            count_next_s = timeout_r;
          end else if (count_r != CNT_ZERO) begin
            count_next_s = count_r - CNT_ONE;
          end else begin
            state_next_s = EXPIRED;
            expire_s     = 1'b1;
          end
        end
        EXPIRED: begin
          if (hb_s) begin
            state_next_s = RUNNING;
            count_next_s = timeout_r;
          end else begin
            state_next_s = EXPIRED;
          end
        end
        default: begin
          state_next_s = DISARMED;
          count_next_s = timeout_r;
        end
      endcase
    end
  end

  // State and countdown registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= DISARMED;
      count_r <= TIMEOUT_RST;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
    end
  end

  // CPU-writable configuration; a zero timeout would expire instantly, so it becomes 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_r  <= 1'b0;
      irq_en_r  <= 1'b0;
      timeout_r <= TIMEOUT_RST;
    end else begin
      if (wr_s && (bus.address == 2'd1)) begin
        enable_r <= bus.writedata[0];
        irq_en_r <= bus.writedata[1];
      end
      if (wr_s && (bus.address == 2'd2)) begin
        timeout_r <= (wr_timeout_s == CNT_ZERO) ? CNT_ONE : wr_timeout_s;
      end
    end
  end

  // Sticky timeout flag; a new expiry outranks a simultaneous W1C clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_flag_r <= 1'b0;
    end else if (expire_s) begin
      timeout_flag_r <= 1'b1;
    end else if (wr_s && (bus.address == 2'd0) && bus.writedata[2]) begin
      timeout_flag_r <= 1'b0;
    end
  end

  // Heartbeat (wrapping) and miss (saturating) counters; a CPU clear outranks increments.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hb_cnt_r   <= 16'd0;
      miss_cnt_r <= 8'd0;
    end else if (wr_s && (bus.address == 2'd3)) begin
      hb_cnt_r   <= 16'd0;
      miss_cnt_r <= 8'd0;
    end else begin
      if (hb_s && (state_r != DISARMED)) begin
        hb_cnt_r <= hb_cnt_r + 16'd1;
      end
      if (expire_s && (miss_cnt_r != 8'hFF)) begin
        miss_cnt_r <= miss_cnt_r + 8'd1;
      end
    end
  end

  assign irq      = timeout_flag_r & irq_en_r;
  assign alive_ok = (state_r == RUNNING);

  // Zero-wait-state read mux.
  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd0:    bus.readdata = {26'd0, alive_q_r, alive_ok, timeout_flag_r, state_r};
      2'd1:    bus.readdata = {30'd0, irq_en_r, enable_r};
      2'd2:    bus.readdata = timeout_rd_s;
      2'd3:    bus.readdata = {8'd0, miss_cnt_r, hb_cnt_r};
      default: bus.readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_alive_monitor.sv
// Self-checking bench for soc_system_alive_monitor: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle against
// a time-based behavioural model (deadline = reload edge + TIMEOUT + 1).
module tb_soc_system_alive_monitor;

  logic       clk;
  logic       reset;
  logic [1:0] alive_in;
  logic       irq;
  logic       alive_ok;

  soc_system_alive_monitor_if bus();

  soc_system_alive_monitor dut (
    .clk      (clk),
    .reset    (reset),
    .alive_in (alive_in),
    .bus      (bus),
    .irq      (irq),
    .alive_ok (alive_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Behavioural model: mode 0=off, 1=waiting for first beat, 2=running, 3=expired.
  int          m_mode;
  logic [1:0]  m_aq;
  logic [1:0]  m_aqq;
  logic        m_en;
  logic        m_ien;
  longint      m_to;
  logic        m_flag;
  int          m_hb;
  int          m_miss;
  longint      m_edge;
  longint      m_load_edge;
  longint      m_load_to;

  task automatic m_reset();
    m_mode = 0; m_aq = 2'b00; m_aqq = 2'b00; m_en = 1'b0; m_ien = 1'b0;
    m_to = 64'd50000000; m_flag = 1'b0; m_hb = 0; m_miss = 0;
    m_edge = 64'd0; m_load_edge = 64'd0; m_load_to = 64'd0;
  endtask

  // Advance the model by one clock edge using the inputs presented to that edge.
  task automatic m_step();
    logic beat, want, wr, expire;
    int   nxt;
    beat   = m_aq[0] ^ m_aqq[0];
    want   = m_aq[1];
    wr     = bus.chipselect && !bus.write_n;
    expire = 1'b0;
    nxt    = m_mode;
    if (!(m_en && want)) begin
      nxt = 0;
    end else if (m_mode == 0) begin
      nxt = 1;
    end else if (beat) begin
      nxt = 2;
      m_load_edge = m_edge;
      m_load_to   = m_to;
    end else if (m_mode == 2 && (m_edge - m_load_edge) == m_load_to + 64'd1) begin
      nxt    = 3;
      expire = 1'b1;
    end
    if (wr && bus.address == 2'd3) begin
      m_hb = 0; m_miss = 0;
    end else begin
      if (beat && m_mode != 0) m_hb = (m_hb + 1) % 65536;
      if (expire && m_miss < 255) m_miss = m_miss + 1;
    end
    if (expire) m_flag = 1'b1;
    else if (wr && bus.address == 2'd0 && bus.writedata[2]) m_flag = 1'b0;
    if (wr && bus.address == 2'd1) begin
      m_en = bus.writedata[0]; m_ien = bus.writedata[1];
    end
    if (wr && bus.address == 2'd2) m_to = (bus.writedata == 32'd0) ? 64'd1 : longint'(bus.writedata);
    m_aqq  = m_aq;
    m_aq   = alive_in;
    m_mode = nxt;
    m_edge = m_edge + 64'd1;
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [1:0] st;
    st = 2'(m_mode);
    case (a)
      2'd0:    m_read = {26'd0, m_aq, (m_mode == 2), m_flag, st};
      2'd1:    m_read = {30'd0, m_ien, m_en};
      2'd2:    m_read = 32'(m_to);
      default: m_read = {8'd0, 8'(m_miss), 16'(m_hb)};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      if (miscompares <= 40) $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: step the model, let the DUT take the edge, compare on the falling edge.
  task automatic tick();
    if (reset) m_reset();
    else m_step();
    @(posedge clk);
    @(negedge clk);
    chk("cyc_irq", 32'(irq), 32'(m_flag & m_ien));
    chk("cyc_alive_ok", 32'(alive_ok), 32'(m_mode == 2));
    chk("cyc_readdata", bus.readdata, m_read(bus.address));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    bus.address = a;
    #1;
    chk(name, bus.readdata, exp);
  endtask

  task automatic toggle();
    alive_in[0] = ~alive_in[0];
  endtask

  logic [31:0] wd;

  initial begin
    vectors = 0; miscompares = 0;
    reset = 1'b1; alive_in = 2'b00;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    m_reset();
    repeat (2) tick();
    reset = 1'b0;
    rd_chk("rst_status", 2'd0, 32'd0);
    rd_chk("rst_control", 2'd1, 32'd0);
    rd_chk("rst_timeout", 2'd2, 32'd50000000);
    rd_chk("rst_count", 2'd3, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_alive_ok", 32'(alive_ok), 32'd0);

    // Arm and run: 20 heartbeats every 5 cycles with TIMEOUT=10.
    alive_in = 2'b10;
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd10);
    repeat (2) tick();
    for (int i = 0; i < 20; i++) begin
      toggle();
      repeat (5) tick();
      chk("run_irq", 32'(irq), 32'd0);
    end
    rd_chk("run_status", 2'd0, 32'h0000002A);
    rd_chk("run_count", 2'd3, 32'h00000014);

    // Timeout: one beat then silence; expiry lands 11 edges after the reload.
    bus.address = 2'd0;
    toggle();
    repeat (12) tick();
    rd_chk("pre_expiry_status", 2'd0, 32'h0000003A);
    tick();
    rd_chk("expiry_status", 2'd0, 32'h00000037);
    chk("expiry_irq", 32'(irq), 32'd1);
    rd_chk("expiry_count", 2'd3, 32'h00010015);
    toggle();
    repeat (2) tick();
    rd_chk("recover_status", 2'd0, 32'h0000002E);
    chk("recover_irq", 32'(irq), 32'd1);
    wr(2'd0, 32'd4);
    chk("w1c_irq", 32'(irq), 32'd0);

    // Heartbeat arriving exactly when the countdown hits zero must win.
    wr(2'd3, 32'd0);
    repeat (7) tick();
    for (int i = 0; i < 3; i++) begin
      toggle();
      repeat (11) tick();
    end
    rd_chk("coinc_status", 2'd0, 32'h0000003A);
    rd_chk("coinc_count", 2'd3, 32'h00000003);

    // W1C on the very edge of a new expiry: the set wins.
    tick();
    wr(2'd0, 32'd4);
    rd_chk("w1c_race_status", 2'd0, 32'h00000037);
    chk("w1c_race_irq", 32'(irq), 32'd1);
    toggle();
    repeat (2) tick();
    wr(2'd0, 32'd4);

    // Disarm while running: DISARMED two edges after the request drops.
    alive_in[1] = 1'b0;
    bus.address = 2'd0;
    tick();
    rd_chk("disarm_mid_status", 2'd0, 32'h0000000A);
    tick();
    rd_chk("disarm_status", 2'd0, 32'h00000000);
    wr(2'd3, 32'd0);
    for (int i = 0; i < 3; i++) begin
      toggle();
      repeat (3) tick();
    end
    rd_chk("disarm_count", 2'd3, 32'h00000000);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      alive_in[1] = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 5) == 0) toggle();
      bus.address = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) begin
        case (bus.address)
          2'd1:    wd = ($urandom_range(0, 7) != 0) ? 32'd3 : $urandom;
          2'd2:    wd = 32'($urandom_range(0, 20));
          default: wd = $urandom;
        endcase
        wr(bus.address, wd);
      end else begin
        tick();
      end
    end

    // Asynchronous reset in the middle of activity.
    reset = 1'b1;
    m_reset();
    rd_chk("midrst_status", 2'd0, 32'd0);
    rd_chk("midrst_control", 2'd1, 32'd0);
    rd_chk("midrst_timeout", 2'd2, 32'd50000000);
    rd_chk("midrst_count", 2'd3, 32'd0);
    chk("midrst_irq", 32'(irq), 32'd0);
    chk("midrst_alive_ok", 32'(alive_ok), 32'd0);
    tick();
    reset = 1'b0;

    // Miss counter saturation with TIMEOUT=1 and 300 expiry/recover rounds.
    alive_in = 2'b10;
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd1);
    tick();
    for (int i = 0; i < 300; i++) begin
      toggle();
      repeat (4) tick();
    end
    rd_chk("sat_count", 2'd3, 32'h00FF012C);

    // Heartbeat counter wrap: 65535 beats, then one more.
    wr(2'd3, 32'd0);
    for (int i = 0; i < 65535; i++) begin
      toggle();
      tick();
    end
    tick();
    bus.address = 2'd3;
    #1;
    chk("wrap_pre", bus.readdata & 32'h0000FFFF, 32'h0000FFFF);
    toggle();
    repeat (2) tick();
    #1;
    chk("wrap_post", bus.readdata & 32'h0000FFFF, 32'h00000000);

    // A zero timeout is stored as 1.
    wr(2'd2, 32'd0);
    rd_chk("timeout_zero", 2'd2, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
